// File: rtl/sha256_pkg.sv
// Shared types and sizing for the SHA-256 message controller.
package sha256_pkg;
  localparam int MAX_MSG_BYTES = 247;
  localparam int MAX_BLOCKS    = 4;
  localparam int BUF_WORDS     = 64;

  typedef enum logic [2:0] {IDLE, ACCEPT, PAD, LENGTH, START, SERVE, DONE} state_t;

  // ceil((len + 9) / 64): 0x80 marker plus 8 length bytes must fit.
  function automatic logic [7:0] blocks_for_len(input logic [7:0] len);
    logic [8:0] t;
    t = {1'b0, len} + 9'd72;
    return {5'b0, t[8:6]};
  endfunction
endpackage

// File: rtl/sha_msg_controller_if.sv
// Message-in, core-service and digest-out signals of the SHA message controller.
interface sha_msg_controller_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         core_start;
  logic         core_enable;
  logic [7:0]   core_num_blocks;
  logic         core_req_word;
  logic [5:0]   core_word_address;
  logic [31:0]  core_word_data;
  logic         core_word_valid;
  logic         core_busy;
  logic         core_hash_valid;
  logic [255:0] core_hash;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         err;

  modport slave (
    input  in_valid, in_data, in_last, core_req_word, core_word_address,
           core_busy, core_hash_valid, core_hash, digest_ready,
    output in_ready, core_start, core_enable, core_num_blocks, core_word_data,
           core_word_valid, digest_valid, digest, err
  );

  modport master (
    output in_valid, in_data, in_last, core_req_word, core_word_address,
           core_busy, core_hash_valid, core_hash, digest_ready,
    input  in_ready, core_start, core_enable, core_num_blocks, core_word_data,
           core_word_valid, digest_valid, digest, err
  );
endinterface

// File: rtl/msg_word_buf.sv
// 64x32 message buffer: big-endian byte-lane writes, registered word read.
module msg_word_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_byte_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic [5:0]  rd_addr,
  input  logic        rd_zero,
  output logic [31:0] rd_data
);
  logic [31:0] mem [BUF_WORDS];

  // Byte 0 of a word lands in bits 31:24, so the lane is the inverted low address bits.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_byte_addr[7:2]][{~wr_byte_addr[1:0], 3'b000} +: 8] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_zero ? 32'h0 : mem[rd_addr];
  end
endmodule

// File: rtl/sha_msg_controller.sv
// Collects a byte-serial message, pads it to SHA-256 blocks and serves words to the core.
module sha_msg_controller
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  sha_msg_controller_if.slave   bus
);
  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  len;
  logic        hv_q;
  logic        hs;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic        rd_zero;
  logic [63:0] len_bits;

  assign bus.in_ready = rst_n && (state == IDLE || state == ACCEPT);
  assign hs       = bus.in_valid && bus.in_ready;
  assign len_bits = {53'b0, len, 3'b000};
  assign rd_en    = (state == SERVE) && bus.core_req_word && !bus.core_word_valid;
  assign rd_zero  = {6'b0, bus.core_word_address} >= {bus.core_num_blocks, 4'b0000};

  always_comb begin
    wr_en   = 1'b0;
    wr_data = bus.in_data;
    case (state)
      IDLE, ACCEPT: wr_en = hs && (cnt != 8'(MAX_MSG_BYTES));
      PAD: begin
        wr_en   = 1'b1;
        wr_data = (cnt == len) ? 8'h80 : 8'h00;
      end
      LENGTH: begin
        wr_en   = 1'b1;
        wr_data = len_bits[{~cnt[2:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  msg_word_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_byte_addr (cnt),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (bus.core_word_address),
    .rd_zero      (rd_zero),
    .rd_data      (bus.core_word_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      len                 <= '0;
      hv_q                <= 1'b0;
      bus.core_start      <= 1'b0;
      bus.core_enable     <= 1'b0;
      bus.core_num_blocks <= '0;
      bus.core_word_valid <= 1'b0;
      bus.digest_valid    <= 1'b0;
      bus.digest          <= '0;
      bus.err             <= 1'b0;
    end else begin
      bus.core_start      <= 1'b0;
      bus.core_word_valid <= 1'b0;
      bus.err             <= 1'b0;
      hv_q                <= bus.core_hash_valid;
      case (state)
        IDLE: if (hs) begin
          cnt <= 8'd1;
          if (bus.in_last) begin
            len   <= 8'd1;
            state <= PAD;
          end else begin
            state <= ACCEPT;
          end
        end
        ACCEPT: if (hs) begin
          if (cnt == 8'(MAX_MSG_BYTES)) begin
            bus.err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (bus.in_last) begin
              len   <= cnt + 8'd1;
              state <= PAD;
            end
          end
        end
        // Stop padding once the next byte index is 56 mod 64.
        PAD: begin
          cnt <= cnt + 8'd1;
          if (cnt[5:0] == 6'd55) state <= LENGTH;
        end
        LENGTH: begin
          cnt <= cnt + 8'd1;
          if (cnt[2:0] == 3'd7) begin
            bus.core_start      <= 1'b1;
            bus.core_enable     <= 1'b1;
            bus.core_num_blocks <= blocks_for_len(len);
            state               <= START;
          end
        end
        START: state <= SERVE;
        SERVE: begin
          if (bus.core_hash_valid && !hv_q) begin
            bus.digest       <= bus.core_hash;
            bus.digest_valid <= 1'b1;
            bus.core_enable  <= 1'b0;
            state            <= DONE;
          end else if (rd_en) begin
            bus.core_word_valid <= 1'b1;
          end
        end
        DONE: if (bus.digest_ready) begin
          bus.digest_valid    <= 1'b0;
          bus.core_num_blocks <= '0;
          cnt                 <= '0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_msg_controller.sv
// Directed bench: drives messages, models a SHA-256 core and scoreboards served words and digests.
module tb_sha_msg_controller;
  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha_msg_controller_if bus();
  sha_msg_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int dbl = 0;
  logic prev_v = 1'b0;
  logic [7:0]   msg [256];
  logic [31:0]  got_words [64];
  logic [255:0] last_digest;
  logic [31:0]  exp_words [$];
  logic [255:0] exp_digest [$];
  int           exp_nb [$];

  always @(posedge clk) begin
    if (bus.core_start) start_cnt++;
    if (bus.core_word_valid && prev_v) dbl++;
    prev_v = bus.core_word_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  task automatic push_expected(input int len);
    logic [7:0] b [256];
    logic [63:0] lb;
    logic [511:0] blk;
    logic [255:0] h;
    int nb;
    nb = (len + 72) / 64;
    for (int i = 0; i < 256; i++) b[i] = (i < len) ? msg[i] : 8'h00;
    b[len] = 8'h80;
    lb = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) b[nb*64 - 8 + k] = lb[8*(7-k) +: 8];
    h = IV;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = b[64*k + j];
      for (int w = 0; w < 16; w++) exp_words.push_back(blk[511 - 32*w -: 32]);
      h = sha_blk(h, blk);
    end
    exp_digest.push_back(h);
    exp_nb.push_back(nb);
  endtask

  task automatic send_msg(input int len, input bit with_last);
    int t;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = with_last && (i == len - 1);
      t = 0;
      while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
      if (t == 50) chk("in_ready_timeout", 256'(bus.in_ready), 256'(1));
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic fetch(input int a, output logic [31:0] d, output int cyc);
    bus.core_req_word     = 1'b1;
    bus.core_word_address = a[5:0];
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.core_word_valid && cyc < 20);
    chk("word_valid_seen", 256'(bus.core_word_valid), 256'(1));
    d = bus.core_word_data;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (!bus.core_start && t < 1000) begin @(negedge clk); t++; end
    chk("core_start_seen", 256'(bus.core_start), 256'(1));
  endtask

  task automatic serve_core(input int hold);
    int nb, cyc, pulses, bad, t;
    logic [255:0] h, ed;
    logic [31:0] d, ew;
    logic [511:0] blk;
    bit stable;
    nb = exp_nb.pop_front();
    ed = exp_digest.pop_front();
    wait_start();
    chk("enable_at_start", 256'(bus.core_enable), 256'(1));
    chk("num_blocks", 256'(bus.core_num_blocks), 256'(nb));
    h = IV;
    for (int k = 0; k < nb; k++) begin
      pulses = 0; bad = 0;
      for (int w = 0; w < 16; w++) begin
        fetch(16*k + w, d, cyc);
        if (bus.core_word_valid) pulses++;
        if (w > 0 && cyc != 2) bad++;
        got_words[16*k + w] = d;
        ew = exp_words.pop_front();
        chk("word_data", 256'(d), 256'(ew));
        blk[511 - 32*w -: 32] = d;
      end
      h = sha_blk(h, blk);
      chk("pulses_per_block", 256'(pulses), 256'(16));
      chk("alternate_cycles", 256'(bad), 256'(0));
      chk("enable_in_serve", 256'(bus.core_enable), 256'(1));
      chk("num_blocks_stable", 256'(bus.core_num_blocks), 256'(nb));
    end
    if (nb < 4) begin
      fetch(16*nb, d, cyc);
      chk("out_of_range_zero", 256'(d), 256'(0));
    end
    bus.core_req_word = 1'b0;
    @(negedge clk);
    bus.core_hash = h;
    bus.core_hash_valid = 1'b1;
    @(negedge clk);
    bus.core_hash_valid = 1'b0;
    t = 0;
    while (!bus.digest_valid && t < 20) begin @(negedge clk); t++; end
    chk("digest_valid", 256'(bus.digest_valid), 256'(1));
    chk("digest", bus.digest, ed);
    last_digest = bus.digest;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (bus.digest !== last_digest || bus.digest_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      chk("digest_hold_stable", 256'(stable), 256'(1));
    end
    bus.digest_ready = 1'b1;
    @(negedge clk);
    bus.digest_ready = 1'b0;
    chk("digest_valid_cleared", 256'(bus.digest_valid), 256'(0));
    chk("in_ready_after_done", 256'(bus.in_ready), 256'(1));
  endtask

  task automatic run_msg(input int len, input int hold);
    int s0;
    s0 = start_cnt;
    push_expected(len);
    send_msg(len, 1'b1);
    serve_core(hold);
    chk("single_start_pulse", 256'(start_cnt - s0), 256'(1));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst_core_start", 256'(bus.core_start), 256'(0));
    chk("rst_core_enable", 256'(bus.core_enable), 256'(0));
    chk("rst_num_blocks", 256'(bus.core_num_blocks), 256'(0));
    chk("rst_word_valid", 256'(bus.core_word_valid), 256'(0));
    chk("rst_word_data", 256'(bus.core_word_data), 256'(0));
    chk("rst_digest_valid", 256'(bus.digest_valid), 256'(0));
    chk("rst_digest", bus.digest, 256'(0));
    chk("rst_err", 256'(bus.err), 256'(0));
  endtask

  initial begin
    int s0, cyc;
    logic [31:0] d;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    bus.core_req_word = 1'b0; bus.core_word_address = 6'd0; bus.core_busy = 1'b0;
    bus.core_hash_valid = 1'b0; bus.core_hash = '0; bus.digest_ready = 1'b0;
    #3;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 256'(bus.in_ready), 256'(1));

    fill_abc();
    run_msg(3, 20);
    chk("abc_word0", 256'(got_words[0]), 256'(32'h61626380));
    chk("abc_word15", 256'(got_words[15]), 256'(32'h00000018));
    chk("abc_digest", last_digest, ABC);

    fill_rand(55);
    run_msg(55, 0);
    fill_rand(56);
    run_msg(56, 0);
    chk("len56_word31", 256'(got_words[31]), 256'(32'h000001C0));
    fill_rand(247);
    run_msg(247, 3);

    fill_rand(248);
    s0 = start_cnt;
    send_msg(248, 1'b0);
    chk("oversize_err", 256'(bus.err), 256'(1));
    chk("oversize_idle", 256'(bus.in_ready), 256'(1));
    @(negedge clk);
    chk("oversize_err_pulse", 256'(bus.err), 256'(0));
    repeat (100) @(negedge clk);
    chk("oversize_no_start", 256'(start_cnt - s0), 256'(0));

    fill_abc();
    run_msg(3, 0);
    chk("abc_after_err", last_digest, ABC);

    send_msg(3, 1'b1);
    wait_start();
    fetch(0, d, cyc);
    chk("pre_reset_word0", 256'(d), 256'(32'h61626380));
    fetch(1, d, cyc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    bus.core_req_word = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 256'(bus.in_ready), 256'(1));
    fill_abc();
    run_msg(3, 0);
    chk("abc_after_reset", last_digest, ABC);
    chk("no_back_to_back_valid", 256'(dbl), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha_msg_controller.md
SHA_MSG_CONTROLLER -- requirements
Module: sha_msg_controller

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  input  1, in_ready  output  1, in_data  input  8, in_last  input  1  byte-serial message, valid/ready handshake, in_last marks final byte.
REQ-004 SHALL have ports: core_start  output  1, core_enable  output  1, core_num_blocks  output  8  sequence the compression core.
REQ-005 SHALL have ports: core_req_word  input  1, core_word_address  input  6, core_word_data  output  32, core_word_valid  output  1  word service to the core.
REQ-006 SHALL have ports: core_busy  input  1, core_hash_valid  input  1, core_hash  input  256  core status/result.
REQ-007 SHALL have ports: digest_valid  output  1, digest_ready  input  1, digest  output  256, err  output  1  result to consumer; err flags an oversize message.

Function
REQ-008 SHALL implement states IDLE, ACCEPT, PAD, LENGTH, START, SERVE, DONE.
REQ-009 IDLE: in_ready=1; first accepted byte -> ACCEPT (or PAD if in_last).
REQ-010 ACCEPT: in_ready=1; one byte per handshake cycle written big-endian into a 64x32 word buffer (byte i -> word i/4, lane 3-(i%4), lane 3 = bits 31:24); 8-bit byte counter; in_last -> PAD.
REQ-011 Message length SHALL be 1..247 bytes; if 247 bytes are accepted without in_last, the 248th handshake SHALL pulse err for 1 cycle, discard the message, return to IDLE; no core_start.
REQ-012 PAD: in_ready=0; write 0x80 at byte L, then 0x00 one byte per cycle until byte index %64 == 56 -> LENGTH.
REQ-013 LENGTH: write 64-bit big-endian bit length (L*8) over 8 cycles into final bytes of last block -> START.
REQ-014 core_num_blocks SHALL equal ceil((L+9)/64), range 1..4, stable from START until DONE exits.
REQ-015 START: core_enable=1, core_start=1 for exactly one cycle -> SERVE; core_enable SHALL stay 1 through SERVE.
REQ-016 SERVE: in a cycle where core_req_word=1 and core_word_valid=0, sample core_word_address; next cycle drive core_word_valid=1 with core_word_data = buffer[address]; core_word_valid SHALL never be high two consecutive cycles, so each word is delivered exactly once.
REQ-017 core_word_address >= 16*core_num_blocks SHALL return 32'h0 (no fault).
REQ-018 SERVE -> DONE on rising edge of core_hash_valid (0 then 1 in consecutive cycles); capture core_hash into digest that cycle+1, digest_valid=1.
REQ-019 DONE: hold digest and digest_valid until digest_ready=1 sampled; then digest_valid=0 -> IDLE. New input SHALL NOT be accepted outside IDLE/ACCEPT.
REQ-020 core_word_valid, core_start SHALL be 0 in every state except as specified above.

Reset
REQ-021 On rst_n=0 (any state, incl. mid-SERVE) SHALL asynchronously force: state IDLE, in_ready 0 during reset then 1 in IDLE, core_start 0, core_enable 0, core_num_blocks 0, core_word_valid 0, core_word_data 0, digest_valid 0, digest 0, err 0, byte counter 0.
REQ-022 Word buffer contents SHALL NOT require reset; unwritten words are always covered by PAD/LENGTH writes before use.

Structure
REQ-023 Shared package sha256_pkg SHALL hold state enum type, MAX_MSG_BYTES=247, MAX_BLOCKS=4, BUF_WORDS=64.
REQ-024 Word buffer SHALL be a sub-module msg_word_buf: 64x32, synchronous byte-lane write, 1-cycle registered read.

Verification
REQ-025 "abc" (3 bytes) -> core_num_blocks=1, word0=32'h61626380, word15=32'h00000018, digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-026 55-byte message -> core_num_blocks=1; 56-byte message -> core_num_blocks=2, word31=32'h000001C0.
REQ-027 247-byte message -> core_num_blocks=4, core_start single pulse; 248 bytes without in_last -> err 1-cycle pulse, no core_start, back to IDLE.
REQ-028 digest_ready held 0 for 20 cycles after digest_valid -> digest stable, in_ready=0; digest_ready=1 -> digest_valid=0 next cycle, in_ready=1.
REQ-029 Continuous core_req_word=1 across 16 addresses -> exactly 16 core_word_valid pulses, alternating cycles, data matches buffer per address.
REQ-030 rst_n asserted mid-SERVE -> all outputs at REQ-021 values immediately; following "abc" run produces correct digest.
